// File: rtl/obstacle_spawner_pkg.sv
// Shared game definitions for the obstacle spawner: control states, field
// widths and the substitute value used when a captured seed would be zero.
package obstacle_spawner_pkg;

    localparam int unsigned SEED_W  = 4;
    localparam int unsigned RND_W   = 8;
    localparam int unsigned LANE_W  = 2;
    localparam int unsigned KIND_W  = 2;
    localparam int unsigned COUNT_W = 8;

    // The generator locks up on an all-zero seed, so zero is replaced by this.
    localparam logic [SEED_W-1:0] SEED_SUBST = 4'hA;

    typedef enum logic [2:0] {
        IDLE,
        SEED,
        DRAW,
        WAIT,
        OFFER
    } state_t;

    function automatic logic [SEED_W-1:0] safe_seed(input logic [SEED_W-1:0] raw);
        return (raw == '0) ? SEED_SUBST : raw;
    endfunction

endpackage

// File: rtl/obstacle_spawner.sv
// Obstacle spawner: seeds the random generator at game start, then uses its
// bytes to pick a frame-counted gap and, when the gap expires, a lane and kind
// that are offered to the playfield over a valid/ready handshake.
module obstacle_spawner
    import obstacle_spawner_pkg::*;
#(
    parameter int unsigned MIN_GAP = 8,
    parameter int unsigned CNT_W   = 5
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                stop,
    input  logic                frame_tick,
    input  logic [RND_W-1:0]    rnd,
    output logic [SEED_W-1:0]   seed,
    output logic                load,
    output logic                spawn_valid,
    input  logic                spawn_ready,
    output logic [LANE_W-1:0]   spawn_lane,
    output logic [KIND_W-1:0]   spawn_kind,
    output logic [COUNT_W-1:0]  spawn_count,
    output logic                busy
);

    state_t              state;
    state_t              state_next;
    logic [SEED_W-1:0]   fcnt;
    logic [CNT_W-1:0]    cnt;

    logic                load_next;
    logic                valid_next;
    logic                busy_next;

    logic                game_start;
    logic                capture;
    logic                transfer;
    logic                gap_load;
    logic                gap_step;

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode; stop overrides every other request
    always_comb begin
        state_next = state;
        if (stop) begin
            state_next = IDLE;
        end else begin
            unique case (state)
                IDLE:    if (start) state_next = SEED;
                SEED:    state_next = DRAW;
                DRAW:    state_next = WAIT;
                WAIT:    if (frame_tick && cnt == CNT_W'(1)) state_next = OFFER;
                OFFER:   if (spawn_valid && spawn_ready) state_next = DRAW;
                default: state_next = IDLE;
            endcase
        end
    end

    // Output decode: next values of the registered control outputs and datapath enables
    always_comb begin
        game_start = (state == IDLE)  && (state_next == SEED);
        capture    = (state == WAIT)  && (state_next == OFFER);
        transfer   = (state == OFFER) && (state_next == DRAW);
        gap_load   = (state == DRAW)  && (state_next == WAIT);
        gap_step   = (state == WAIT)  && (state_next == WAIT) && frame_tick;
        load_next  = game_start;
        valid_next = (state_next == OFFER);
        busy_next  = (state_next != IDLE);
    end

    // Registered control outputs, so nothing flows combinationally from inputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            load        <= 1'b0;
            spawn_valid <= 1'b0;
            busy        <= 1'b0;
        end else begin
            load        <= load_next;
            spawn_valid <= valid_next;
            busy        <= busy_next;
        end
    end

    // Free-running entropy counter used for the seed
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fcnt <= '0;
        end else begin
            fcnt <= fcnt + SEED_W'(1);
        end
    end

    // Seed capture at game start; held until the next game
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            seed <= '0;
        end else if (game_start) begin
            seed <= safe_seed(fcnt);
        end
    end

    // Frame gap counter: loaded from the high nibble in DRAW, stepped on frame ticks
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (gap_load) begin
            cnt <= CNT_W'(MIN_GAP) + CNT_W'(rnd[7:4]);
        end else if (gap_step) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    // Lane/kind are cleared at game start and frozen from capture until the next capture
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            spawn_lane <= '0;
            spawn_kind <= '0;
        end else if (game_start) begin
            spawn_lane <= '0;
            spawn_kind <= '0;
        end else if (capture) begin
            spawn_lane <= rnd[1:0];
            spawn_kind <= rnd[3:2];
        end
    end

    // Accepted-spawn counter, wraps naturally at its width
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            spawn_count <= '0;
        end else if (game_start) begin
            spawn_count <= '0;
        end else if (transfer) begin
            spawn_count <= spawn_count + COUNT_W'(1);
        end
    end

endmodule

// File: tb/tb_obstacle_spawner.sv
// Bench for obstacle_spawner: a directed vector table, hand sequences for the
// multi-cycle corners, and a randomized run checked against a reference model.
module tb_obstacle_spawner;

    localparam int MIN_GAP = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       frame_tick = 1'b0;
    logic [7:0] rnd = 8'h00;
    logic       spawn_ready = 1'b0;
    logic [3:0] seed;
    logic       load;
    logic       spawn_valid;
    logic [1:0] spawn_lane;
    logic [1:0] spawn_kind;
    logic [7:0] spawn_count;
    logic       busy;

    int total = 0;
    int bad = 0;

    obstacle_spawner #(.MIN_GAP(8), .CNT_W(5)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .stop       (stop),
        .frame_tick (frame_tick),
        .rnd        (rnd),
        .seed       (seed),
        .load       (load),
        .spawn_valid(spawn_valid),
        .spawn_ready(spawn_ready),
        .spawn_lane (spawn_lane),
        .spawn_kind (spawn_kind),
        .spawn_count(spawn_count),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Reference model: game on/off, setup clocks left, frames left, pending offer
    int m_fcnt, m_on, m_setup, m_gap, m_offer, m_seed, m_lane, m_kind, m_count, m_accepts;

    task automatic model_reset();
        m_fcnt = 0; m_on = 0; m_setup = 0; m_gap = 0; m_offer = 0;
        m_seed = 0; m_lane = 0; m_kind = 0; m_count = 0;
    endtask

    task automatic model_step(input logic st, input logic sp, input logic ft,
                              input logic [7:0] r, input logic rd);
        int prev;
        prev = m_fcnt;
        m_fcnt = (m_fcnt + 1) % 16;
        if (m_on == 0) begin
            if (st && !sp) begin
                m_on = 1; m_setup = 2; m_offer = 0;
                m_seed = (prev == 0) ? 10 : prev;
                m_count = 0; m_lane = 0; m_kind = 0;
            end
        end else if (sp) begin
            m_on = 0; m_offer = 0; m_setup = 0;
        end else if (m_setup == 2) begin
            m_setup = 1;
        end else if (m_setup == 1) begin
            m_gap = MIN_GAP + int'(r) / 16;
            m_setup = 0;
        end else if (m_offer != 0) begin
            if (rd) begin
                m_count = (m_count + 1) % 256;
                m_accepts++;
                m_offer = 0;
                m_setup = 1;
            end
        end else if (ft) begin
            if (m_gap == 1) begin
                m_lane = int'(r) % 4;
                m_kind = (int'(r) / 4) % 4;
                m_offer = 1;
            end else begin
                m_gap--;
            end
        end
    endtask

    function automatic logic [31:0] pack(input logic l, input logic v, input logic b,
                                         input logic [3:0] s, input logic [1:0] ln,
                                         input logic [1:0] k, input logic [7:0] c);
        return {13'd0, l, v, b, s, ln, k, c};
    endfunction

    function automatic logic [31:0] dut_pack();
        return pack(load, spawn_valid, busy, seed, spawn_lane, spawn_kind, spawn_count);
    endfunction

    function automatic logic [31:0] model_pack();
        return pack(m_on != 0 && m_setup == 2, m_offer != 0, m_on != 0, 4'(m_seed),
                    2'(m_lane), 2'(m_kind), 8'(m_count));
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle of inputs, advance one edge, compare against the model
    task automatic tick(input logic st, input logic sp, input logic ft,
                        input logic [7:0] r, input logic rd);
        start = st; stop = sp; frame_tick = ft; rnd = r; spawn_ready = rd;
        @(posedge clk);
        model_step(st, sp, ft, r, rd);
        #1;
        chk("model", dut_pack(), model_pack());
    endtask

    typedef struct {
        logic       st, sp, ft;
        logic [7:0] r;
        logic       rd;
        logic       e_load, e_valid, e_busy;
        logic [3:0] e_seed;
        logic [1:0] e_lane, e_kind;
        logic [7:0] e_count;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic st, input logic sp, input logic ft, input logic [7:0] r,
                       input logic rd, input logic el, input logic ev, input logic eb,
                       input logic [3:0] es, input logic [1:0] eln, input logic [1:0] ek,
                       input logic [7:0] ec);
        vec_t v;
        v.st = st; v.sp = sp; v.ft = ft; v.r = r; v.rd = rd;
        v.e_load = el; v.e_valid = ev; v.e_busy = eb; v.e_seed = es;
        v.e_lane = eln; v.e_kind = ek; v.e_count = ec;
        vecs.push_back(v);
    endtask

    initial begin
        int wrap_base;
        int wrap_seen;

        m_accepts = 0;
        model_reset();

        // Idle after reset: five edges sampled with fcnt 0..4
        for (int i = 0; i < 5; i++) add(0, 0, 0, 8'h00, 0, 0, 0, 0, 4'h0, 2'd0, 2'd0, 8'd0);
        // Start sampled with fcnt=5 -> SEED: load, seed 5, busy, spawn outputs quiet
        add(1, 0, 0, 8'h00, 0, 1, 0, 1, 4'h5, 2'd0, 2'd0, 8'd0);
        // SEED -> DRAW, load drops
        add(0, 0, 0, 8'hFF, 0, 0, 0, 1, 4'h5, 2'd0, 2'd0, 8'd0);
        // DRAW with rnd=3B: gap 11
        add(0, 0, 0, 8'h3B, 0, 0, 0, 1, 4'h5, 2'd0, 2'd0, 8'd0);
        // Ten ticks (with one idle cycle mixed in) leave no offer
        for (int i = 0; i < 10; i++) begin
            add(0, 0, 1, 8'h0E, 0, 0, 0, 1, 4'h5, 2'd0, 2'd0, 8'd0);
            if (i == 4) add(0, 0, 0, 8'h0E, 1, 0, 0, 1, 4'h5, 2'd0, 2'd0, 8'd0);
        end
        // Eleventh tick with rnd=0E: lane 2, kind 3
        add(0, 0, 1, 8'h0E, 0, 0, 1, 1, 4'h5, 2'd2, 2'd3, 8'd0);
        // Backpressure with frame ticks: offer held stable, no count
        for (int i = 0; i < 20; i++) add(0, 0, 1, 8'hF5, 0, 0, 1, 1, 4'h5, 2'd2, 2'd3, 8'd0);
        // Accept: one transfer, back to DRAW
        add(0, 0, 1, 8'hF5, 1, 0, 0, 1, 4'h5, 2'd2, 2'd3, 8'd1);

        #22;
        rst = 1'b1;

        foreach (vecs[i]) begin
            tick(vecs[i].st, vecs[i].sp, vecs[i].ft, vecs[i].r, vecs[i].rd);
            chk($sformatf("vec%0d", i), dut_pack(),
                pack(vecs[i].e_load, vecs[i].e_valid, vecs[i].e_busy, vecs[i].e_seed,
                     vecs[i].e_lane, vecs[i].e_kind, vecs[i].e_count));
        end

        // Stop together with ready (and start) in OFFER: no transfer, back to IDLE
        tick(0, 0, 0, 8'h00, 0);
        for (int i = 0; i < 8; i++) tick(0, 0, 1, 8'h07, 0);
        chk("offer2_valid_lane", {29'd0, spawn_valid, spawn_lane}, {29'd0, 1'b1, 2'd3});
        tick(1, 1, 1, 8'h00, 1);
        chk("stop_offer", {22'd0, spawn_valid, busy, spawn_count}, {22'd0, 1'b0, 1'b0, 8'd1});
        tick(0, 0, 0, 8'h00, 0);
        chk("stop_stays_idle", {31'd0, busy}, 32'd0);

        // Start with fcnt=0 must seed with the substitute value
        for (int i = 0; i < 16 && m_fcnt != 0; i++) tick(0, 0, 0, 8'h00, 0);
        tick(1, 0, 0, 8'h00, 0);
        chk("zero_seed", {27'd0, load, seed}, {27'd0, 1'b1, 4'hA});

        // One spawn (lane 1, kind 2), then async reset part way through the next gap
        tick(0, 0, 0, 8'h00, 0);
        tick(0, 0, 0, 8'h05, 0);
        for (int i = 0; i < 7; i++) tick(0, 0, 1, 8'h00, 0);
        tick(0, 0, 1, 8'h09, 0);
        chk("spawn_lk", {28'd0, spawn_lane, spawn_kind}, {28'd0, 2'd1, 2'd2});
        tick(0, 0, 0, 8'h00, 1);
        chk("spawn_cnt1", {24'd0, spawn_count}, 32'd1);
        tick(0, 0, 0, 8'h40, 0);
        for (int i = 0; i < 3; i++) tick(0, 0, 1, 8'h00, 0);
        #2;
        rst = 1'b0;
        model_reset();
        #1;
        chk("async_rst", dut_pack(), 32'd0);
        #3;
        rst = 1'b1;

        // Randomized play against the model
        for (int i = 0; i < 3000; i++) begin
            tick($urandom_range(0, 39) == 0, $urandom_range(0, 79) == 0,
                 $urandom_range(0, 2) == 0, 8'($urandom), $urandom_range(0, 2) != 0);
        end

        // 256 accepted spawns wrap the counter to zero
        tick(0, 1, 0, 8'h00, 0);
        tick(1, 0, 0, 8'h00, 0);
        wrap_base = m_accepts;
        wrap_seen = 0;
        for (int i = 0; i < 4000 && wrap_seen < 256; i++) begin
            tick(0, 0, 1, 8'h00, 1);
            wrap_seen = m_accepts - wrap_base;
        end
        chk("wrap_accepts", 32'(wrap_seen), 32'd256);
        chk("wrap_count", {24'd0, spawn_count}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/obstacle_spawner.md
# obstacle_spawner

Consumer end of the random-number path: seeds the 8-bit random generator at game start, then draws its random bytes to schedule obstacle spawns. Each draw sets a frame-counted gap and, at expiry, an obstacle lane and kind, offered to the playfield logic over a valid/ready handshake. Sits between the random generator and the obstacle/render pipeline.

## Interface
- MIN_GAP, 8: minimum frames between spawns; must be ≥1.
- CNT_W, 5: gap counter width; must hold MIN_GAP+15.
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse: begin a game (seed + schedule).
- stop  in  1  level/pulse: abort to IDLE.
- frame_tick  in  1  one-cycle pulse per video frame.
- rnd  in  8  random byte from generator, new value every clk.
- seed  out  4  seed driven to generator.
- load  out  1  one-cycle seed-load strobe to generator.
- spawn_valid  out  1  obstacle offer valid.
- spawn_ready  in  1  playfield accepts offer.
- spawn_lane  out  2  lane 0..3.
- spawn_kind  out  2  obstacle type 0..3.
- spawn_count  out  8  accepted spawns since start, wraps 255→0.
- busy  out  1  high in any state except IDLE.

## Operation
- Free-running 4-bit counter `fcnt` increments every clk from reset; it supplies seed entropy.
- States: IDLE, SEED, DRAW, WAIT, OFFER.
- IDLE: outputs quiet. On start (and not stop): latch seed_reg = fcnt, with 0 replaced by 4'hA (all-zero seed forbidden). Clear spawn_count. → SEED.
- SEED: load=1 for exactly this one cycle, seed=seed_reg. → DRAW.
- DRAW: gap counter cnt = MIN_GAP + rnd[7:4] (zero-extended, CNT_W bits). → WAIT.
- WAIT: on frame_tick, if cnt==1 then capture spawn_lane=rnd[1:0], spawn_kind=rnd[3:2] and → OFFER; otherwise cnt−1. Without frame_tick, hold. OFFER is entered exactly (MIN_GAP+rnd[7:4]) frame_ticks after DRAW.
- OFFER: spawn_valid=1. lane and kind are held stable until accepted. Transfer occurs when spawn_valid && spawn_ready: spawn_count+1 (mod 256), → DRAW. frame_tick is ignored in OFFER; gaps do not accumulate during backpressure.
- stop in any state: → IDLE next cycle. spawn_valid drops even mid-offer with no transfer counted. stop wins over simultaneous start or spawn_ready.
- start outside IDLE is ignored.
- seed holds seed_reg at all times after the first start, and 0 before the first start.

## Timing
- Reset values: seed=0, load=0, spawn_valid=0, spawn_lane=0, spawn_kind=0, spawn_count=0, busy=0. State is IDLE, cnt=0, fcnt=0.
- All outputs are registered. Nothing combinational from inputs to outputs.
- start sampled at edge N: load=1 during cycle N+1, DRAW in cycle N+2, WAIT from N+3.
- The rnd used for the gap is the value present in the DRAW cycle. The rnd used for lane/kind is the value present in the final WAIT cycle.
- After a transfer at edge M, DRAW occurs in cycle M+1, so consecutive spawns are separated by ≥ MIN_GAP frames plus 2 clk.
- Reset mid-operation: immediate return to the reset values and IDLE; the generator is reseeded only by the next start.

## Structure
- Shared game package: state enum (IDLE, SEED, DRAW, WAIT, OFFER), the lane/kind widths, and the nonzero-seed substitute constant 4'hA.
- Single module; no sub-module is needed. The gap counter stays inline.
- Integration: seed/load connect directly to the random generator's seed/load inputs; its 8-bit output drives rnd.

## Test plan
- Reset then start with fcnt=5 → load high for one cycle with seed=5, busy=1, all spawn outputs 0 during SEED.
- fcnt=0 at start → seed=4'hA.
- rnd=8'h3B at DRAW (gap 8+3=11), rnd=8'h0E at the 11th frame_tick → spawn_valid with lane=2, kind=3 in the following cycle. No spawn after 10 ticks.
- Hold spawn_ready=0 for 20 cycles with frame_ticks in OFFER → lane/kind stable, count unchanged. Raise ready → one transfer, spawn_count=1, next DRAW.
- stop asserted together with spawn_ready in OFFER → spawn_valid=0 next cycle, spawn_count unchanged, state IDLE, busy=0.
- 256 accepted spawns → spawn_count wraps to 0. Async rst low mid-WAIT → all outputs return to reset values without waiting for a clk edge.
